// File: rtl/pipelined_writeback_if.sv
// Handshake and data bundle between the memory stage, data memory and the
// registered writeback stage.
interface pipelined_writeback_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned OFS_W = $clog2(XLEN / 8);

  logic             in_valid;
  logic             in_ready;
  logic             r_we;
  logic [1:0]       r_dst;
  logic [1:0]       rw_d;
  logic [XLEN-1:0]  alu_out;
  logic [XLEN-1:0]  pc;
  logic [31:0]      insn;
  logic [1:0]       mem_read_size;
  logic             mem_sign_extend;
  logic [OFS_W-1:0] mem_addr_lo;
  logic             dmem_rvalid;
  logic [XLEN-1:0]  dmem_rdata;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [XLEN-1:0]  rf_wd;
  logic             load_misalign;
  logic [31:0]      retire_count;

  modport master (
    output in_valid, r_we, r_dst, rw_d, alu_out, pc, insn, mem_read_size, mem_sign_extend,
    output mem_addr_lo, dmem_rvalid, dmem_rdata,
    input  in_ready, rf_we, rf_wa, rf_wd, load_misalign, retire_count
  );

  modport slave (
    input  in_valid, r_we, r_dst, rw_d, alu_out, pc, insn, mem_read_size, mem_sign_extend,
    input  mem_addr_lo, dmem_rvalid, dmem_rdata,
    output in_ready, rf_we, rf_wa, rf_wd, load_misalign, retire_count
  );
endinterface

// File: rtl/pipelined_writeback.sv
// Registered writeback stage: waits for load data, extracts big-endian byte/halfword
// lanes, drives a registered register-file write port and counts retirements.
module pipelined_writeback #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned LINK_REG    = 31,
  parameter int unsigned LINK_OFFSET = 8
) (
  input logic                  clk,
  input logic                  reset,
  pipelined_writeback_if.slave wb
);
  localparam int unsigned OFS_W = $clog2(XLEN / 8);

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  typedef struct packed {
    logic             r_we;
    logic [1:0]       r_dst;
    logic [1:0]       rw_d;
    logic [XLEN-1:0]  alu_out;
    logic [XLEN-1:0]  pc;
    logic [9:0]       insn_regs;  // insn[20:11]
    logic [1:0]       size;
    logic             sign;
    logic [OFS_W-1:0] ofs;
  } stage_t;

  state_e          state_q;
  stage_t          stage_q;
  stage_t          live;
  stage_t          cur;
  logic            rf_we_q;
  logic [4:0]      rf_wa_q;
  logic [XLEN-1:0] rf_wd_q;
  logic            misalign_q;
  logic [31:0]     retire_q;

  logic            accept;
  logic            commit;
  logic            is_load;
  logic            misalign_raw;
  logic            misalign_c;
  logic            we_c;
  logic [4:0]      addr_c;
  logic [XLEN-1:0] wd_c;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_f;
  logic [15:0]     half_f;
  logic            unused_insn;

  assign unused_insn = ^{wb.insn[31:21], wb.insn[10:0]};

  always_comb begin
    live           = '0;
    live.r_we      = wb.r_we;
    live.r_dst     = wb.r_dst;
    live.rw_d      = wb.rw_d;
    live.alu_out   = wb.alu_out;
    live.pc        = wb.pc;
    live.insn_regs = wb.insn[20:11];
    live.size      = wb.mem_read_size;
    live.sign      = wb.mem_sign_extend;
    live.ofs       = wb.mem_addr_lo;
  end

  // While waiting on memory the captured instruction drives the commit path.
  assign cur     = (state_q == StWaitMem) ? stage_q : live;
  assign is_load = (cur.rw_d == 2'd1);
  assign accept  = (state_q == StIdle) && wb.in_valid;
  assign commit  = (accept && (!is_load || wb.dmem_rvalid)) ||
                   ((state_q == StWaitMem) && wb.dmem_rvalid);

  // Left-shifting by the byte offset brings lane k to the top of the word.
  assign shifted = wb.dmem_rdata << {cur.ofs, 3'b000};
  assign byte_f  = shifted[XLEN-1 -: 8];
  assign half_f  = shifted[XLEN-1 -: 16];

  always_comb begin
    load_val     = wb.dmem_rdata;
    misalign_raw = 1'b0;
    case (cur.size)
      2'd1: begin
        load_val     = {{(XLEN-16){cur.sign & half_f[15]}}, half_f};
        misalign_raw = cur.ofs[0];
      end
      2'd2: begin
        load_val     = {{(XLEN-8){cur.sign & byte_f[7]}}, byte_f};
        misalign_raw = 1'b0;
      end
      default: begin
        load_val     = wb.dmem_rdata;
        misalign_raw = |cur.ofs;
      end
    endcase
  end

  always_comb begin
    addr_c = 5'(LINK_REG);
    case (cur.r_dst)
      2'd0:    addr_c = cur.insn_regs[9:5];
      2'd1:    addr_c = cur.insn_regs[4:0];
      default: addr_c = 5'(LINK_REG);
    endcase
  end

  always_comb begin
    wd_c = cur.alu_out;
    case (cur.rw_d)
      2'd1:    wd_c = load_val;
      2'd2:    wd_c = cur.pc + XLEN'(LINK_OFFSET);
      default: wd_c = cur.alu_out;
    endcase
  end

  assign misalign_c = is_load && misalign_raw;
  assign we_c       = cur.r_we && (addr_c != 5'd0) && !misalign_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      stage_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= 5'd0;
      rf_wd_q    <= '0;
      misalign_q <= 1'b0;
      retire_q   <= 32'd0;
    end else begin
      rf_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      if (accept) begin
        stage_q <= live;
      end
      if (commit) begin
        rf_we_q    <= we_c;
        rf_wa_q    <= addr_c;
        rf_wd_q    <= wd_c;
        misalign_q <= misalign_c;
        retire_q   <= retire_q + 32'd1;
      end
      case (state_q)
        StIdle: begin
          if (accept && is_load && !wb.dmem_rvalid) begin
            state_q <= StWaitMem;
          end
        end
        StWaitMem: begin
          if (wb.dmem_rvalid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb.in_ready      = (state_q == StIdle);
  assign wb.rf_we         = rf_we_q;
  assign wb.rf_wa         = rf_wa_q;
  assign wb.rf_wd         = rf_wd_q;
  assign wb.load_misalign = misalign_q;
  assign wb.retire_count  = retire_q;
endmodule

// File: doc/pipelined_writeback.md
Name: pipelined_writeback

Overview:
- Registered, parametrised successor to the combinational writeback stage.
- Accepts one retiring instruction per cycle from the memory stage.
- Waits on multi-cycle data-memory returns, extracts and extends byte/halfword loads at any aligned offset (big-endian lanes), and drives a registered register-file write port.
- Also flags misaligned loads and counts retired instructions.

Parameters:
- XLEN, 32, datapath width in bits; must be 32 or 64.
- LINK_REG, 31, destination register for link writes (r_dst = 2 or 3).
- LINK_OFFSET, 8, value added to pc for link writeback (rw_d = 2).
- OFS_W, $clog2(XLEN/8), width of the byte-offset field (derived; not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept; high when FSM is IDLE
- r_we  in  1  instruction writes a register
- r_dst  in  2  0 = insn[20:16], 1 = insn[15:11], 2/3 = LINK_REG
- rw_d  in  2  0 = alu_out, 1 = memory, 2 = pc+LINK_OFFSET, 3 = alu_out
- alu_out  in  XLEN  ALU result
- pc  in  XLEN  instruction pc
- insn  in  32  instruction word
- mem_read_size  in  2  0 = full XLEN, 1 = halfword, 2 = byte, 3 = treated as 0
- mem_sign_extend  in  1  1 = sign-extend, 0 = zero-extend
- mem_addr_lo  in  OFS_W  low bits of the load address
- dmem_rvalid  in  1  load data valid this cycle
- dmem_rdata  in  XLEN  load data
- rf_we  out  1  register-file write enable (registered)
- rf_wa  out  5  register-file write address (registered)
- rf_wd  out  XLEN  register-file write data (registered)
- load_misalign  out  1  one-cycle pulse on a misaligned load commit
- retire_count  out  32  number of instructions committed

Behaviour:
- Reset (async): state = IDLE; rf_we = 0, rf_wa = 0, rf_wd = 0, load_misalign = 0, retire_count = 0. in_ready = 1 while in reset, since state is IDLE.
- Accept: in_valid && in_ready at edge t. All inputs are captured into the stage register.
- FSM: two states, IDLE and WAIT_MEM.
  - IDLE, accept, rw_d != 1: commit at t, so outputs are valid from t+1. Stay in IDLE.
  - IDLE, accept, rw_d == 1, dmem_rvalid high at t: commit at t using dmem_rdata. Stay in IDLE.
  - IDLE, accept, rw_d == 1, dmem_rvalid low: go to WAIT_MEM. in_ready = 0.
  - WAIT_MEM: on the first cycle with dmem_rvalid high, commit with that data and return to IDLE. in_ready rises the cycle after.
- Commit: rf_we and load_misalign are single-cycle pulses. rf_wa and rf_wd hold their values until the next commit. retire_count += 1 on every commit, wrapping at 2^32.
- rf_we is asserted at commit unless any of these holds: r_we = 0; resolved address = 0 (r0 writes dropped); the load is misaligned.
- Address resolution: r_dst 0 -> insn[20:16]; r_dst 1 -> insn[15:11]; r_dst 2/3 -> LINK_REG.
- Load extraction (big-endian; offset k selects byte dmem_rdata[XLEN-1-8k -: 8]):
  - byte: any offset.
  - halfword: offset must be even; selects the 16 bits starting at byte k.
  - full: offset must be 0.
  - Selected field is sign-extended to XLEN if mem_sign_extend = 1, zero-extended if 0.
- Misaligned: halfword at an odd offset, or full with a nonzero offset.
  - Commit still occurs and retire_count increments.
  - rf_we = 0; load_misalign = 1 for one cycle.
- Link: rf_wd = pc + LINK_OFFSET, truncated to XLEN.
- dmem_rvalid while IDLE with no load being accepted: ignored.
- Reset asserted during WAIT_MEM: pending instruction is dropped with no write and no count increment.
- No output depends combinationally on any data input. in_ready depends on state only.

Test Plan:
- Byte load: mem_read_size = 2, sign = 1, mem_addr_lo = 1, dmem_rdata = 0x12F45678 in the accept cycle, r_dst = 0, insn[20:16] = 5 -> next cycle rf_we = 1, rf_wa = 5, rf_wd = 0xFFFFFFF4, retire_count = 1.
- Halfword, zero-extend: mem_read_size = 1, sign = 0, mem_addr_lo = 2, dmem_rdata = 0x1234ABCD -> rf_wd = 0x0000ABCD. Same with sign = 1 -> 0xFFFFABCD.
- Memory wait: accept a load with dmem_rvalid low, then dmem_rvalid high 3 cycles later with 0xDEADBEEF, full size -> in_ready low for 3 cycles. rf_we pulses the cycle after rvalid with rf_wd = 0xDEADBEEF. in_ready high again one cycle after rvalid. No spurious writes while waiting.
- Back-to-back ALU ops plus link: 4 consecutive accepts with rw_d = 0, then rw_d = 2 with pc = 0x00000400 and r_dst = 2 -> 5 consecutive rf_we pulses; the last has rf_wa = 31, rf_wd = 0x00000408; retire_count = 5.
- Suppression:
  - r_dst = 1 with insn[15:11] = 0 -> rf_we = 0, count increments.
  - Halfword load at offset 1 -> rf_we = 0, load_misalign = 1 for one cycle.
- Reset mid-wait: assert reset while in WAIT_MEM -> all outputs 0, in_ready = 1. A late dmem_rvalid after reset produces no write.
